// File: rtl/sequencer_pkg.sv
// Shared types for the multicycle processor control path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents:
//   state_t        - 4-bit sequencer state encoding, IDLE = 0
//   TIMER_W        - width of the memory wait timer (covers TIMEOUT up to 255)
//   retire_target  - state to enter after an instruction retires
package sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    GET_PC    = 4'd1,
    ROM_READ  = 4'd2,
    DECODE    = 4'd3,
    COND_EVAL = 4'd4,
    REG_READ  = 4'd5,
    ALU       = 4'd6,
    RAM       = 4'd7,
    BRANCH    = 4'd8,
    WRITE_REG = 4'd9,
    INC_PC    = 4'd10,
    PAUSE     = 4'd11,
    DONE      = 4'd12,
    ERROR     = 4'd13
  } state_t;

  localparam int TIMER_W = 8;

  // Halt has priority over single-step; otherwise fetch the next instruction.
  function automatic state_t retire_target(input logic haltReq, input logic stepMode);
    if (haltReq)       return DONE;
    else if (stepMode) return PAUSE;
    else               return GET_PC;
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Sequencer <-> datapath bundle: stage enables out, decode info and memory acks in.
// Latency: n/a (wires only).
// Backpressure: rom_ack/ram_ack hold the sequencer in its memory-wait state.
// Modports:
//   master - sequencer side (drives en_*, samples acks and decode fields)
//   slave  - datapath side (samples en_*, drives acks and decode fields)
interface multicycle_sequencer_if;
  logic rom_ack;
  logic ram_ack;
  logic is_cond;
  logic cond_pass;
  logic op_alu;
  logic op_mem;
  logic op_branch;
  logic set_flags_only;
  logic mem_load;

  logic en_get_pc;
  logic en_rom;
  logic en_decode;
  logic en_eval;
  logic en_reg_read;
  logic en_alu;
  logic en_ram;
  logic en_bx;
  logic en_reg_write;
  logic en_inc_pc;

  modport master (
    input  rom_ack, ram_ack, is_cond, cond_pass, op_alu, op_mem, op_branch,
           set_flags_only, mem_load,
    output en_get_pc, en_rom, en_decode, en_eval, en_reg_read, en_alu, en_ram,
           en_bx, en_reg_write, en_inc_pc
  );

  modport slave (
    output rom_ack, ram_ack, is_cond, cond_pass, op_alu, op_mem, op_branch,
           set_flags_only, mem_load,
    input  en_get_pc, en_rom, en_decode, en_eval, en_reg_read, en_alu, en_ram,
           en_bx, en_reg_write, en_inc_pc
  );
endinterface

// File: rtl/wait_timer.sv
// Counts cycles spent waiting for a memory ack; flags when the limit is reached.
// Latency: expired is a combinational compare of the registered count.
// Backpressure: none; the count saturates at TIMEOUT.
// Ports: clk, rst (async high), load (clear to 0), count (advance), expired (timer == TIMEOUT).
module wait_timer
  import sequencer_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expired
);

  logic [TIMER_W-1:0] timer;

  assign expired = (timer == TIMER_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     timer <= '0;
    else if (load)               timer <= '0;
    else if (count && !expired)  timer <= timer + 1'b1;
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Control FSM stepping one instruction through fetch/decode/execute/write-back/PC increment.
// Latency: 7 cycles for a zero-wait ALU op, +1 per conditional, +1 per ROM/RAM wait cycle.
// Backpressure: waits in ROM_READ/RAM for ack; goes to ERROR after TIMEOUT unacked cycles.
// Ports: clk, rst (async high); start, halt_req, step_mode, step control; bus (datapath
//   enables, decode fields, memory acks); busy/done/error status; state_o debug;
//   cycle_count, retired_count performance counters.
module multicycle_sequencer
  import sequencer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   halt_req,
  input  logic                   step_mode,
  input  logic                   step,
  multicycle_sequencer_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [3:0]             state_o,
  output logic [CNT_W-1:0]       cycle_count,
  output logic [CNT_W-1:0]       retired_count
);

  state_t state, nextState;
  logic   prevBranch;   // previous cycle was BRANCH: this WRITE_REG is the link write
  logic   inWait;
  logic   expired;
  logic   classOneHot;
  logic   isRetire;

  assign classOneHot = (bus.op_alu ^ bus.op_mem ^ bus.op_branch) &
                       ~(bus.op_alu & bus.op_mem & bus.op_branch);
  assign isRetire    = (state == INC_PC) || (state == WRITE_REG && prevBranch);
  assign inWait      = (state == ROM_READ) || (state == RAM);

  // Timer is held at zero outside the wait states, so it starts from 0 on every entry.
  wait_timer #(.TIMEOUT(TIMEOUT)) uTimer (
    .clk     (clk),
    .rst     (rst),
    .load    (!inWait),
    .count   ((state == ROM_READ && !bus.rom_ack) || (state == RAM && !bus.ram_ack)),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prevBranch <= 1'b0;
    end else begin
      state      <= nextState;
      prevBranch <= (state == BRANCH);
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (start) nextState = GET_PC;
      GET_PC:    nextState = halt_req ? DONE : ROM_READ;
      // An ack arriving in the same cycle the limit is reached still wins.
      ROM_READ:  if (bus.rom_ack)  nextState = DECODE;
                 else if (expired) nextState = ERROR;
      DECODE:    if (!classOneHot)     nextState = ERROR;
                 else if (bus.is_cond) nextState = COND_EVAL;
                 else                  nextState = REG_READ;
      COND_EVAL: nextState = bus.cond_pass ? REG_READ : INC_PC;
      REG_READ:  if (bus.op_alu)      nextState = ALU;
                 else if (bus.op_mem) nextState = RAM;
                 else                 nextState = BRANCH;
      ALU:       nextState = bus.set_flags_only ? INC_PC : WRITE_REG;
      RAM:       if (bus.ram_ack)  nextState = bus.mem_load ? WRITE_REG : INC_PC;
                 else if (expired) nextState = ERROR;
      BRANCH:    nextState = WRITE_REG;
      // Branch link write already set the PC: retire without incrementing.
      WRITE_REG: nextState = prevBranch ? retire_target(halt_req, step_mode) : INC_PC;
      INC_PC:    nextState = retire_target(halt_req, step_mode);
      PAUSE:     if (halt_req)  nextState = DONE;
                 else if (step) nextState = GET_PC;
      DONE:      nextState = DONE;
      ERROR:     nextState = ERROR;
      default:   nextState = ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count   <= '0;
      retired_count <= '0;
    end else begin
      if (busy)     cycle_count   <= cycle_count + CNT_W'(1);
      if (isRetire) retired_count <= retired_count + CNT_W'(1);
    end
  end

  assign bus.en_get_pc    = (state == GET_PC);
  assign bus.en_rom       = (state == ROM_READ);
  assign bus.en_decode    = (state == DECODE);
  assign bus.en_eval      = (state == COND_EVAL);
  assign bus.en_reg_read  = (state == REG_READ);
  assign bus.en_alu       = (state == ALU);
  assign bus.en_ram       = (state == RAM);
  assign bus.en_bx        = (state == BRANCH);
  assign bus.en_reg_write = (state == WRITE_REG);
  assign bus.en_inc_pc    = (state == INC_PC);

  assign busy    = !(state == IDLE || state == PAUSE || state == DONE || state == ERROR);
  assign done    = (state == DONE);
  assign error   = (state == ERROR);
  assign state_o = state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer (TIMEOUT = 4).
// Inputs are driven 1 ns after the rising edge; outputs are checked at the same point.
module tb_multicycle_sequencer;
  import sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, halt_req, step_mode, step;
  logic        busy, done, error;
  logic [3:0]  state_o;
  logic [31:0] cycle_count, retired_count;
  int          total = 0;
  int          bad   = 0;

  multicycle_sequencer_if sif();

  multicycle_sequencer #(.CNT_W(32), .TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .halt_req      (halt_req),
    .step_mode     (step_mode),
    .step          (step),
    .bus           (sif),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .state_o       (state_o),
    .cycle_count   (cycle_count),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  wire [9:0] enVec = {sif.en_get_pc, sif.en_rom, sif.en_decode, sif.en_eval, sif.en_reg_read,
                      sif.en_alu, sif.en_ram, sif.en_bx, sif.en_reg_write, sif.en_inc_pc};

  function automatic logic [9:0] expEn(input state_t s);
    case (s)
      GET_PC:    return 10'b1000000000;
      ROM_READ:  return 10'b0100000000;
      DECODE:    return 10'b0010000000;
      COND_EVAL: return 10'b0001000000;
      REG_READ:  return 10'b0000100000;
      ALU:       return 10'b0000010000;
      RAM:       return 10'b0000001000;
      BRANCH:    return 10'b0000000100;
      WRITE_REG: return 10'b0000000010;
      INC_PC:    return 10'b0000000001;
      default:   return 10'b0000000000;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs;
    start = 0; halt_req = 0; step_mode = 0; step = 0;
    sif.rom_ack = 0; sif.ram_ack = 0; sif.is_cond = 0; sif.cond_pass = 0;
    sif.op_alu = 0; sif.op_mem = 0; sif.op_branch = 0; sif.set_flags_only = 0; sif.mem_load = 0;
  endtask

  task automatic doReset;
    clearInputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    clearInputs();
    rst = 1;
    tick();
    total++; if (state_o !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_o); end
    total++; if (enVec !== 10'd0) begin bad++; $display("FAIL reset_en got=%b want=0", enVec); end
    total++; if ({busy, done, error} !== 3'b000) begin bad++; $display("FAIL reset_status got=%b want=000", {busy, done, error}); end
    total++; if (cycle_count !== 32'd0 || retired_count !== 32'd0) begin bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", cycle_count, retired_count); end
    rst = 0;
    tick();
    total++; if (state_o !== 4'(IDLE)) begin bad++; $display("FAIL idle_hold got=%0d want=0", state_o); end
  endtask

  task automatic test_alu;
    state_t seq [8];
    seq = '{GET_PC, ROM_READ, DECODE, REG_READ, ALU, WRITE_REG, INC_PC, PAUSE};
    doReset();
    step_mode = 1; sif.op_alu = 1; sif.rom_ack = 1; sif.ram_ack = 1; start = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) start = 0;
      total++; if (state_o !== 4'(seq[i])) begin bad++; $display("FAIL alu_state[%0d] got=%0d want=%0d", i, state_o, seq[i]); end
      total++; if (enVec !== expEn(seq[i])) begin bad++; $display("FAIL alu_en[%0d] got=%b want=%b", i, enVec, expEn(seq[i])); end
    end
    total++; if (retired_count !== 32'd1) begin bad++; $display("FAIL alu_retired got=%0d want=1", retired_count); end
    total++; if (cycle_count !== 32'd7) begin bad++; $display("FAIL alu_cycles got=%0d want=7", cycle_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL alu_pause_busy got=%b want=0", busy); end
  endtask

  // Continues from PAUSE left by test_alu: one step pulse runs exactly one more instruction.
  task automatic test_back_to_back;
    state_t seq [10];
    seq = '{GET_PC, ROM_READ, DECODE, REG_READ, ALU, WRITE_REG, INC_PC, PAUSE, PAUSE, PAUSE};
    step = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) step = 0;
      total++; if (state_o !== 4'(seq[i])) begin bad++; $display("FAIL b2b_state[%0d] got=%0d want=%0d", i, state_o, seq[i]); end
    end
    total++; if (retired_count !== 32'd2) begin bad++; $display("FAIL b2b_retired got=%0d want=2", retired_count); end
    total++; if (cycle_count !== 32'd14) begin bad++; $display("FAIL b2b_cycles got=%0d want=14", cycle_count); end
  endtask

  task automatic test_cond_squash;
    state_t seq [6];
    logic   sawReg = 1'b0;
    seq = '{GET_PC, ROM_READ, DECODE, COND_EVAL, INC_PC, PAUSE};
    doReset();
    step_mode = 1; sif.op_alu = 1; sif.is_cond = 1; sif.cond_pass = 0; sif.rom_ack = 1; start = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) start = 0;
      sawReg = sawReg | sif.en_reg_read | sif.en_reg_write;
      total++; if (state_o !== 4'(seq[i])) begin bad++; $display("FAIL cond_state[%0d] got=%0d want=%0d", i, state_o, seq[i]); end
    end
    total++; if (sawReg !== 1'b0) begin bad++; $display("FAIL cond_reg_access got=%b want=0", sawReg); end
    total++; if (retired_count !== 32'd1) begin bad++; $display("FAIL cond_retired got=%0d want=1", retired_count); end
    total++; if (cycle_count !== 32'd5) begin bad++; $display("FAIL cond_cycles got=%0d want=5", cycle_count); end
  endtask

  task automatic test_load_store;
    state_t ld [11];
    state_t st [7];
    int     ramCycles = 0;
    ld = '{GET_PC, ROM_READ, DECODE, REG_READ, RAM, RAM, RAM, RAM, WRITE_REG, INC_PC, PAUSE};
    st = '{GET_PC, ROM_READ, DECODE, REG_READ, RAM, INC_PC, PAUSE};
    doReset();
    step_mode = 1; sif.op_mem = 1; sif.mem_load = 1; sif.rom_ack = 1; sif.ram_ack = 0; start = 1;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i == 0) start = 0;
      if (sif.en_ram) ramCycles++;
      sif.ram_ack = (i == 7);   // ack during the fourth RAM cycle
      total++; if (state_o !== 4'(ld[i])) begin bad++; $display("FAIL load_state[%0d] got=%0d want=%0d", i, state_o, ld[i]); end
    end
    total++; if (ramCycles != 4) begin bad++; $display("FAIL load_ram_cycles got=%0d want=4", ramCycles); end
    total++; if (cycle_count !== 32'd10) begin bad++; $display("FAIL load_cycles got=%0d want=10", cycle_count); end
    sif.mem_load = 0; sif.ram_ack = 1; step = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) step = 0;
      total++; if (state_o !== 4'(st[i])) begin bad++; $display("FAIL store_state[%0d] got=%0d want=%0d", i, state_o, st[i]); end
    end
    total++; if (retired_count !== 32'd2) begin bad++; $display("FAIL store_retired got=%0d want=2", retired_count); end
  endtask

  task automatic test_timeout;
    state_t to [7];
    state_t ok [8];
    to = '{GET_PC, ROM_READ, ROM_READ, ROM_READ, ROM_READ, ROM_READ, ERROR};
    ok = '{GET_PC, ROM_READ, ROM_READ, ROM_READ, ROM_READ, ROM_READ, DECODE, ERROR};
    doReset();
    step_mode = 1; sif.op_alu = 1; sif.rom_ack = 0; start = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) start = 0;
      total++; if (state_o !== 4'(to[i])) begin bad++; $display("FAIL timeout_state[%0d] got=%0d want=%0d", i, state_o, to[i]); end
    end
    total++; if ({busy, error} !== 2'b01) begin bad++; $display("FAIL timeout_status got=%b want=01", {busy, error}); end
    start = 1; sif.rom_ack = 1;
    tick(); tick(); tick();
    total++; if (error !== 1'b1 || state_o !== 4'(ERROR)) begin bad++; $display("FAIL error_sticky got=%b/%0d want=1/13", error, state_o); end
    doReset();
    total++; if (error !== 1'b0) begin bad++; $display("FAIL error_cleared got=%b want=0", error); end
    // Ack on the limit cycle reaches DECODE; an all-zero class then faults there.
    step_mode = 1; sif.rom_ack = 0; start = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) start = 0;
      sif.rom_ack = (i == 5);
      total++; if (state_o !== 4'(ok[i])) begin bad++; $display("FAIL late_ack_state[%0d] got=%0d want=%0d", i, state_o, ok[i]); end
    end
  endtask

  task automatic test_branch_step;
    state_t seq [15];
    logic   sawInc = 1'b0;
    seq = '{GET_PC, ROM_READ, DECODE, REG_READ, BRANCH, WRITE_REG,
            GET_PC, ROM_READ, DECODE, REG_READ, BRANCH, WRITE_REG, PAUSE, PAUSE, PAUSE};
    doReset();
    step_mode = 0; sif.op_branch = 1; sif.rom_ack = 1; start = 1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i == 0) start = 0;
      if (i == 6) begin
        step_mode = 1;
        total++; if (retired_count !== 32'd1) begin bad++; $display("FAIL branch_retire1 got=%0d want=1", retired_count); end
      end
      sawInc = sawInc | sif.en_inc_pc;
      total++; if (state_o !== 4'(seq[i])) begin bad++; $display("FAIL branch_state[%0d] got=%0d want=%0d", i, state_o, seq[i]); end
    end
    total++; if (sawInc !== 1'b0) begin bad++; $display("FAIL branch_inc_pc got=%b want=0", sawInc); end
    total++; if (retired_count !== 32'd2) begin bad++; $display("FAIL branch_retired got=%0d want=2", retired_count); end
    total++; if (cycle_count !== 32'd12) begin bad++; $display("FAIL branch_cycles got=%0d want=12", cycle_count); end
    halt_req = 1; step = 1;
    tick();
    total++; if (state_o !== 4'(DONE) || done !== 1'b1) begin bad++; $display("FAIL pause_halt_wins got=%0d/%b want=12/1", state_o, done); end
  endtask

  task automatic test_halt;
    state_t seq [8];
    seq = '{GET_PC, ROM_READ, DECODE, REG_READ, ALU, WRITE_REG, INC_PC, DONE};
    doReset();
    sif.op_alu = 1; sif.rom_ack = 1; start = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) start = 0;
      if (i == 4) halt_req = 1;
      total++; if (state_o !== 4'(seq[i])) begin bad++; $display("FAIL halt_state[%0d] got=%0d want=%0d", i, state_o, seq[i]); end
    end
    total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL halt_status got=%b want=01", {busy, done}); end
    total++; if (retired_count !== 32'd1 || cycle_count !== 32'd7) begin bad++; $display("FAIL halt_counters got=%0d/%0d want=1/7", retired_count, cycle_count); end
    halt_req = 0; start = 1;
    tick(); tick();
    total++; if (state_o !== 4'(DONE)) begin bad++; $display("FAIL done_sticky got=%0d want=12", state_o); end
  endtask

  task automatic test_reset_mid;
    state_t seq [5];
    seq = '{GET_PC, ROM_READ, DECODE, REG_READ, RAM};
    doReset();
    sif.op_mem = 1; sif.mem_load = 1; sif.rom_ack = 1; sif.ram_ack = 0; start = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) start = 0;
    end
    total++; if (state_o !== 4'(seq[4])) begin bad++; $display("FAIL midrst_pre got=%0d want=7", state_o); end
    #2 rst = 1;
    #1;
    total++; if (state_o !== 4'd0 || enVec !== 10'd0) begin bad++; $display("FAIL midrst_outputs got=%0d/%b want=0/0", state_o, enVec); end
    total++; if ({busy, done, error} !== 3'b000 || cycle_count !== 32'd0) begin bad++; $display("FAIL midrst_status got=%b/%0d want=000/0", {busy, done, error}, cycle_count); end
    tick();
    rst = 0;
    tick();
    total++; if (state_o !== 4'(IDLE)) begin bad++; $display("FAIL midrst_idle got=%0d want=0", state_o); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_cond_squash();
    test_load_store();
    test_timeout();
    test_branch_step();
    test_halt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
